// File: rtl/mem_ctrl.sv
// mem_ctrl: one-at-a-time memory access sequencer (IDLE -> ACCESS -> DONE).
// Ports: CLK, RST(n); CON[2]=rd CON[5]=wr, MAR_IN, MBR_IN, MEM_RDATA, MEM_ACK in;
//        MEM_ADDR, MEM_WDATA, MEM_REQ, MEM_WE, RD_DATA, RD_VALID, BUSY, ERR out.
module mem_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] CON,
  input  logic [7:0]  MAR_IN,
  input  logic [15:0] MBR_IN,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic [7:0]  MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [15:0] RD_DATA,
  output logic        RD_VALID,
  output logic        BUSY,
  output logic        ERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [7:0]  r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [15:0] r_rd_data;
  logic        r_rd_valid;
  logic        r_busy;
  logic        r_err;

  logic        w_rd_req;
  logic        w_wr_req;
  logic        w_req;
  logic [3:0]  w_cnt_inc;
  logic        w_last_wait;
  logic        w_unused_con;

  assign w_rd_req = CON[2];
  assign w_wr_req = CON[5];
  assign w_req    = w_rd_req | w_wr_req;

  assign w_unused_con = ^{CON[31:6], CON[4:3], CON[1:0]};

  // The counter reaching TIMEOUT on this edge marks the last
  // unacknowledged cycle we are willing to wait.
  assign w_cnt_inc   = r_cnt + 4'd1;
  assign w_last_wait = (w_cnt_inc == 4'(TIMEOUT));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_mem_addr  <= 8'd0;
      r_mem_wdata <= 16'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_rd_data   <= 16'd0;
      r_rd_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        // The DONE exit edge behaves like IDLE so back-to-back
        // requests see only one dead cycle on MEM_REQ; CON seen
        // on the acknowledge edge itself is dropped.
        IDLE, DONE: begin
          r_rd_valid <= 1'b0;
          if (w_req) begin
            r_state    <= ACCESS;
            r_mem_addr <= MAR_IN;
            if (w_wr_req) begin
              r_mem_wdata <= MBR_IN;
            end
            r_mem_req <= 1'b1;
            r_mem_we  <= w_wr_req;
            r_cnt     <= 4'd0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        ACCESS: begin
          if (MEM_ACK) begin
            // Acknowledge wins over a simultaneous timeout.
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (!r_mem_we) begin
              r_rd_data  <= MEM_RDATA;
              r_rd_valid <= 1'b1;
            end
          end else if (w_last_wait) begin
            r_state   <= DONE;
            r_cnt     <= w_cnt_inc;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_err     <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WDATA = r_mem_wdata;
  assign MEM_REQ   = r_mem_req;
  assign MEM_WE    = r_mem_we;
  assign RD_DATA   = r_rd_data;
  assign RD_VALID  = r_rd_valid;
  assign BUSY      = r_busy;
  assign ERR       = r_err;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed table plus randomized transactions for mem_ctrl.
// Expected outputs come from per-transaction arithmetic (ack delay vs TIMEOUT).
module tb_mem_ctrl;

  localparam int TMO = 15;

  logic        CLK;
  logic        RST;
  logic [31:0] CON;
  logic [7:0]  MAR_IN;
  logic [15:0] MBR_IN;
  logic [15:0] MEM_RDATA;
  logic        MEM_ACK;
  logic [7:0]  MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [15:0] RD_DATA;
  logic        RD_VALID;
  logic        BUSY;
  logic        ERR;

  mem_ctrl #(.TIMEOUT(TMO)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CON       (CON),
    .MAR_IN    (MAR_IN),
    .MBR_IN    (MBR_IN),
    .MEM_RDATA (MEM_RDATA),
    .MEM_ACK   (MEM_ACK),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_REQ   (MEM_REQ),
    .MEM_WE    (MEM_WE),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
    .BUSY      (BUSY),
    .ERR       (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          ack_at;
    int          gap;
    int          exp_len;
    logic        exp_valid;
    logic        exp_err;
    logic [15:0] exp_rd;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rd;
  logic        m_err;

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " req"},   16'(MEM_REQ),  16'd0);
    chk({tag, " we"},    16'(MEM_WE),   16'd0);
    chk({tag, " busy"},  16'(BUSY),     16'd0);
    chk({tag, " valid"}, 16'(RD_VALID), 16'd0);
    chk({tag, " err"},   16'(ERR),      16'd0);
    chk({tag, " addr"},  16'(MEM_ADDR), 16'd0);
    chk({tag, " wdata"}, MEM_WDATA,     16'd0);
    chk({tag, " rdata"}, RD_DATA,       16'd0);
  endtask

  // One access: request edge, ack_at-th access edge (or timeout), then idle gap.
  task automatic run_txn(input logic wr, input logic rd,
                         input logic [7:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rdata, input int ack_at,
                         input int gap, input int exp_len,
                         input logic exp_valid, input logic exp_err,
                         input logic [15:0] exp_rd, input string tag);
    CON = ($urandom & ~32'h24) | {26'd0, wr, 2'b00, rd, 2'b00};
    MAR_IN = addr;
    MBR_IN = wdata;
    MEM_ACK = 1'($urandom);
    MEM_RDATA = 16'($urandom);
    tick();
    m_addr = addr;
    if (wr) m_wdata = wdata;
    chk({tag, " e0 req"},  16'(MEM_REQ),  16'd1);
    chk({tag, " e0 we"},   16'(MEM_WE),   16'(wr));
    chk({tag, " e0 addr"}, 16'(MEM_ADDR), 16'(m_addr));
    chk({tag, " e0 wd"},   MEM_WDATA,     m_wdata);
    chk({tag, " e0 busy"}, 16'(BUSY),     16'd1);
    chk({tag, " e0 vld"},  16'(RD_VALID), 16'd0);
    chk({tag, " e0 err"},  16'(ERR),      16'd0);
    for (int k = 1; k <= exp_len; k++) begin
      CON = $urandom;
      MAR_IN = 8'($urandom);
      MBR_IN = 16'($urandom);
      MEM_ACK = (k == ack_at);
      MEM_RDATA = (k == ack_at) ? rdata : 16'($urandom);
      tick();
      if (k < exp_len) begin
        chk({tag, " acc req"},  16'(MEM_REQ),  16'd1);
        chk({tag, " acc we"},   16'(MEM_WE),   16'(wr));
        chk({tag, " acc addr"}, 16'(MEM_ADDR), 16'(m_addr));
        chk({tag, " acc wd"},   MEM_WDATA,     m_wdata);
        chk({tag, " acc vld"},  16'(RD_VALID), 16'd0);
        chk({tag, " acc rd"},   RD_DATA,       m_rd);
      end
    end
    m_rd = exp_rd;
    m_err = exp_err;
    chk({tag, " end req"},  16'(MEM_REQ),  16'd0);
    chk({tag, " end we"},   16'(MEM_WE),   16'd0);
    chk({tag, " end busy"}, 16'(BUSY),     16'd1);
    chk({tag, " end vld"},  16'(RD_VALID), 16'(exp_valid));
    chk({tag, " end err"},  16'(ERR),      16'(exp_err));
    chk({tag, " end rd"},   RD_DATA,       m_rd);
    for (int g = 0; g < gap; g++) begin
      CON = $urandom & ~32'h24;
      MEM_ACK = 1'($urandom);
      MEM_RDATA = 16'($urandom);
      tick();
      chk({tag, " gap req"},  16'(MEM_REQ),  16'd0);
      chk({tag, " gap we"},   16'(MEM_WE),   16'd0);
      chk({tag, " gap busy"}, 16'(BUSY),     16'd0);
      chk({tag, " gap vld"},  16'(RD_VALID), 16'd0);
      chk({tag, " gap err"},  16'(ERR),      16'(m_err));
      chk({tag, " gap rd"},   RD_DATA,       m_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    tbl[0] = '{1'b0, 1'b1, 8'h3A, 16'h0000, 16'hBEEF, 1,  1, 1,
               1'b1, 1'b0, 16'hBEEF};
    tbl[1] = '{1'b1, 1'b0, 8'h10, 16'h1234, 16'h0BAD, 4,  1, 4,
               1'b0, 1'b0, 16'hBEEF};
    tbl[2] = '{1'b0, 1'b1, 8'h55, 16'h0000, 16'hDEAD, 99, 1, TMO,
               1'b0, 1'b1, 16'hBEEF};
    tbl[3] = '{1'b1, 1'b1, 8'h77, 16'hCAFE, 16'h0BAD, 2,  1, 2,
               1'b0, 1'b0, 16'hBEEF};
    tbl[4] = '{1'b0, 1'b1, 8'h20, 16'h0000, 16'h5A5A, TMO, 0, TMO,
               1'b1, 1'b0, 16'h5A5A};
    tbl[5] = '{1'b0, 1'b1, 8'h21, 16'h0000, 16'h1111, 1,  0, 1,
               1'b1, 1'b0, 16'h1111};
    tbl[6] = '{1'b0, 1'b1, 8'h22, 16'h0000, 16'h2222, 1,  2, 1,
               1'b1, 1'b0, 16'h2222};

    RST = 1'b0;
    CON = 32'd0;
    MAR_IN = 8'd0;
    MBR_IN = 16'd0;
    MEM_RDATA = 16'd0;
    MEM_ACK = 1'b0;
    m_addr = 8'd0;
    m_wdata = 16'd0;
    m_rd = 16'd0;
    m_err = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata,
              tbl[i].rdata, tbl[i].ack_at, tbl[i].gap, tbl[i].exp_len,
              tbl[i].exp_valid, tbl[i].exp_err, tbl[i].exp_rd,
              $sformatf("vec%0d", i));
    end

    // Reset two cycles into an access, then a late acknowledge.
    CON = 32'h4;
    MAR_IN = 8'h99;
    MEM_ACK = 1'b0;
    tick();
    chk("rst-mid e0 req", 16'(MEM_REQ), 16'd1);
    CON = 32'd0;
    tick();
    tick();
    #2;
    RST = 1'b0;
    #1;
    chk_zero("rst-mid async");
    @(negedge CLK);
    RST = 1'b1;
    MEM_ACK = 1'b1;
    MEM_RDATA = 16'hFFFF;
    m_addr = 8'd0;
    m_wdata = 16'd0;
    m_rd = 16'd0;
    m_err = 1'b0;
    tick();
    tick();
    chk("late ack vld",  16'(RD_VALID), 16'd0);
    chk("late ack req",  16'(MEM_REQ),  16'd0);
    chk("late ack busy", 16'(BUSY),     16'd0);
    chk("late ack rd",   RD_DATA,       16'd0);

    // First edge after release accepts a request.
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    run_txn(1'b0, 1'b1, 8'h44, 16'h0, 16'hA5A5, 1, 1, 1,
            1'b1, 1'b0, 16'hA5A5, "post-rst");

    // Randomized transactions against the arithmetic model.
    for (int n = 0; n < 60; n++) begin
      int t;
      int a;
      int gp;
      int len;
      logic wr;
      logic rd;
      logic ok;
      logic [15:0] rdat;
      t = $urandom_range(0, 2);
      wr = (t != 0);
      rd = (t != 1);
      a = $urandom_range(1, TMO + 3);
      gp = (n == 59) ? 1 : $urandom_range(0, 2);
      rdat = 16'($urandom);
      ok = (a <= TMO);
      len = ok ? a : TMO;
      run_txn(wr, rd, 8'($urandom), 16'($urandom), rdat, a, gp, len,
              ok && !wr, !ok, (ok && !wr) ? rdat : m_rd,
              $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
